ours_ppln_pack: RTL

Valid/ready width up-converter that packs RATIO consecutive IN_WIDTH-bit beats into one wide word, with an early-close `last_in` marker for partial words. Sits directly upstream of an `ours_ppln_cell` instance, feeding its `valid_in`/`data_in` and consuming its `ready_out`, so narrow producers (e.g. byte-serial link receivers) can drive wide pipelines. Output is registered; the ready path is combinational and is broken by the downstream cell when that cell is built with TYPE 1 or 3.

---
 rtl/ours_ppln_pack.sv | 104 ++++++++++
 1 files changed

// File: rtl/ours_ppln_pack.sv
// Valid/ready width up-converter: packs RATIO little-endian IN_WIDTH beats into one registered word.
// Define OURS_PPLN_PACK_KEEP_EN to add the keep_out lane-filled mask.

module ours_ppln_pack_lane #(
  parameter int W = 8
) (
  input  logic         sel,
  input  logic [W-1:0] beat,
  input  logic [W-1:0] held,
  output logic [W-1:0] merged
);
  assign merged = sel ? beat : held;
endmodule

module ours_ppln_pack #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO,
  localparam int CNT_W     = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic                 last_in,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 last_out
`ifdef OURS_PPLN_PACK_KEEP_EN
  , output logic [RATIO-1:0]   keep_out
`endif
);

`ifndef SYNTHESIS
  initial begin
    if (RATIO < 2 || IN_WIDTH < 1)
      $fatal(1, "ours_ppln_pack: RATIO must be >= 2 and IN_WIDTH >= 1");
  end
`endif

  logic [CNT_W-1:0]                cnt;
  logic [RATIO-1:0][IN_WIDTH-1:0]  acc;
  logic [RATIO-1:0][IN_WIDTH-1:0]  merged;
  logic [RATIO-1:0]                sel;
  logic                            take;
  logic                            done_beat;

  // Stalled output blocks every beat, including ones that would only accumulate.
  assign ready_out = !valid_out | ready_in;
  assign take      = valid_in & ready_out;
  assign done_beat = take & (last_in | (cnt == CNT_W'(RATIO - 1)));

  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    assign sel[i] = (cnt == CNT_W'(i));
    ours_ppln_pack_lane #(.W(IN_WIDTH)) u_lane (
      .sel    (sel[i]),
      .beat   (data_in),
      .held   (acc[i]),
      .merged (merged[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      last_out  <= 1'b0;
    end else if (done_beat) begin
      // acc is cleared on completion, so unfilled lanes of a partial word stay zero.
      valid_out <= 1'b1;
      data_out  <= merged;
      last_out  <= last_in;
      cnt       <= '0;
      acc       <= '0;
    end else begin
      if (take) begin
        acc <= merged;
        cnt <= cnt + CNT_W'(1);
      end
      if (valid_out && ready_in) valid_out <= 1'b0;
    end
  end

`ifdef OURS_PPLN_PACK_KEEP_EN
  logic [RATIO-1:0] acc_keep;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_keep <= '0;
      keep_out <= '0;
    end else if (done_beat) begin
      keep_out <= acc_keep | sel;
      acc_keep <= '0;
    end else if (take) begin
      acc_keep <= acc_keep | sel;
    end
  end
`endif

endmodule
